dbgu_cmd: RTL

Parametrised byte-stream debug command engine. It sits between the debug UART byte interface and the SoC memory bus, which uses picorv32 native handshake. It generalises the fixed 32-bit debug unit in four ways: configurable address and data widths, burst read/write with a count byte, a CPU reset control, and a status/overrun report. Command opcodes stay compatible with the existing 0x01/0x04/0x05/0x22 protocol.

---
 rtl/dbgu_pkg.sv | 22 ++
 rtl/dbgu_shreg.sv | 32 +++
 rtl/dbgu_cmd.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbgu_pkg.sv
// Shared definitions for the debug command engine.
//   - Command opcodes (compatible with the original 0x01/0x04/0x05/0x22 protocol).
//   - Engine state encoding.
package dbgu_pkg;

  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h04;
  localparam logic [7:0] OP_READ     = 8'h05;
  localparam logic [7:0] OP_BREAD    = 8'h06;
  localparam logic [7:0] OP_BWRITE   = 8'h07;
  localparam logic [7:0] OP_STATUS   = 8'h08;
  localparam logic [7:0] OP_CPU_CLK  = 8'h22;
  localparam logic [7:0] OP_CPU_RST  = 8'h23;

  typedef enum logic [1:0] {
    StIdle,
    StArg,
    StMemReq,
    StTx
  } state_e;

endpackage

// File: rtl/dbgu_shreg.sv
// Little-endian byte shift register.
// A shift pushes a byte in at the top and drops the low byte, so after W/8
// shifts the first byte received sits in bits [7:0]. Shifting in zeros
// serialises a loaded word low byte first through data[7:0].
// Ports:
//   clk, reset  - clock and synchronous active-high reset (clears data)
//   load        - parallel load of load_data (has priority over shift)
//   shift       - shift right by one byte, shift_byte enters at the top
//   data        - current register contents
module dbgu_shreg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic [7:0]   shift_byte,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= (data >> 8) | (W'(shift_byte) << (W - 8));
    end
  end

endmodule

// File: rtl/dbgu_cmd.sv
// Byte-stream debug command engine: decodes commands from the debug UART byte
// stream and performs word accesses on a picorv32-style native memory bus.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   rx_data, rx_valid    - received byte and its one-cycle strobe
//   tx_data, tx_valid    - response byte, held until tx_ready
//   tx_ready             - transmitter accepts the byte
//   mem_valid/addr/wdata/wstrb, mem_ready/rdata - memory bus
//   cpu_clk_en, cpu_reset - CPU control bits
module dbgu_cmd
  import dbgu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter bit          AUTO_INC = 1'b1,
  parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                cpu_clk_en,
  output logic                cpu_reset
);

  localparam int unsigned WB  = DATA_W / 8;
  localparam int unsigned AB  = ADDR_W / 8;
  localparam int unsigned RW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned LSB = $clog2(WB);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << LSB;

  state_e              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          tx_cnt_q, tx_cnt_d;
  logic [7:0]          burst_q, burst_d;
  logic                need_cnt_q, need_cnt_d;
  logic                ptr_load_q, ptr_load_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                overrun_q, overrun_d;
  logic                clk_en_q, clk_en_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                is_write_q, is_write_d;
  logic                is_status_q, is_status_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [WB-1:0]       mem_wstrb_q, mem_wstrb_d;

  logic [3:0]          arg_last;
  logic                rx_shift, tx_load, tx_shift;
  logic [DATA_W-1:0]   tx_load_data;
  logic [RW-1:0]       rx_sh;
  logic [DATA_W-1:0]   tx_sh;

  // Argument bytes accumulate at the top, so the last AB/WB bytes are the field.
  dbgu_shreg #(.W(RW)) u_rx_sh (
    .clk        (clk),
    .reset      (reset),
    .load       (1'b0),
    .load_data  ('0),
    .shift      (rx_shift),
    .shift_byte (rx_data),
    .data       (rx_sh)
  );

  dbgu_shreg #(.W(DATA_W)) u_tx_sh (
    .clk        (clk),
    .reset      (reset),
    .load       (tx_load),
    .load_data  (tx_load_data),
    .shift      (tx_shift),
    .shift_byte (8'h00),
    .data       (tx_sh)
  );

  always_comb begin
    case (op_q)
      OP_SET_ADDR:         arg_last = 4'(AB - 1);
      OP_WRITE, OP_BWRITE: arg_last = 4'(WB - 1);
      default:             arg_last = 4'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    tx_cnt_d     = tx_cnt_q;
    burst_d      = burst_q;
    need_cnt_d   = need_cnt_q;
    ptr_load_d   = 1'b0;
    ptr_d        = ptr_q;
    overrun_d    = overrun_q;
    clk_en_d     = clk_en_q;
    cpu_rst_d    = cpu_rst_q;
    is_write_d   = is_write_q;
    is_status_d  = is_status_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    rx_shift     = 1'b0;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;
    tx_load_data = '0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          op_d        = rx_data;
          cnt_d       = '0;
          tx_cnt_d    = '0;
          burst_d     = '0;
          need_cnt_d  = 1'b0;
          is_status_d = 1'b0;
          is_write_d  = (rx_data == OP_WRITE) || (rx_data == OP_BWRITE);
          case (rx_data)
            OP_SET_ADDR, OP_WRITE, OP_CPU_CLK, OP_CPU_RST: state_d = StArg;
            OP_BREAD, OP_BWRITE: begin
              state_d    = StArg;
              need_cnt_d = 1'b1;
            end
            OP_READ: state_d = StMemReq;
            OP_STATUS: begin
              state_d      = StTx;
              tx_load      = 1'b1;
              tx_load_data = DATA_W'({7'b0, overrun_q});
              is_status_d  = 1'b1;
            end
            default: begin
              state_d      = StTx;
              tx_load      = 1'b1;
              tx_load_data = DATA_W'(NAK_BYTE);
            end
          endcase
        end
      end

      StArg: begin
        if (rx_valid) begin
          if (need_cnt_q) begin
            burst_d    = rx_data;
            need_cnt_d = 1'b0;
            if (op_q == OP_BREAD) state_d = StMemReq;
          end else begin
            rx_shift = 1'b1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == arg_last) begin
              cnt_d   = '0;
              state_d = StIdle;
              case (op_q)
                OP_SET_ADDR: ptr_load_d = 1'b1;
                OP_CPU_CLK:  clk_en_d   = rx_data[0];
                OP_CPU_RST:  cpu_rst_d  = rx_data[0];
                default:     state_d    = StMemReq;
              endcase
            end
          end
        end
      end

      StMemReq: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = ptr_q & ADDR_MASK;
          mem_wdata_d = rx_sh[RW-1 -: DATA_W];
          mem_wstrb_d = is_write_q ? '1 : '0;
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (AUTO_INC) ptr_d = ptr_q + ADDR_W'(WB);
          if (is_write_q) begin
            if (burst_q != 8'd0) begin
              burst_d = burst_q - 8'd1;
              state_d = StArg;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tx_load      = 1'b1;
            tx_load_data = mem_rdata;
            tx_cnt_d     = 4'(WB - 1);
            state_d      = StTx;
          end
        end
      end

      StTx: begin
        if (tx_ready) begin
          if (tx_cnt_q == 4'd0) begin
            if (burst_q != 8'd0) begin
              burst_d = burst_q - 8'd1;
              state_d = StMemReq;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tx_shift = 1'b1;
            tx_cnt_d = tx_cnt_q - 4'd1;
          end
        end
      end
    endcase

    // New address becomes visible one cycle after its last byte lands in rx_sh.
    if (ptr_load_q) ptr_d = rx_sh[RW-1 -: ADDR_W];

    // A dropped strobe outranks the clear from an accepted STATUS byte.
    if (rx_valid && (state_q == StMemReq || state_q == StTx)) begin
      overrun_d = 1'b1;
    end else if (state_q == StTx && tx_ready && is_status_q) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      cnt_q       <= '0;
      tx_cnt_q    <= '0;
      burst_q     <= '0;
      need_cnt_q  <= 1'b0;
      ptr_load_q  <= 1'b0;
      ptr_q       <= '0;
      overrun_q   <= 1'b0;
      clk_en_q    <= 1'b1;
      cpu_rst_q   <= 1'b0;
      is_write_q  <= 1'b0;
      is_status_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      burst_q     <= burst_d;
      need_cnt_q  <= need_cnt_d;
      ptr_load_q  <= ptr_load_d;
      ptr_q       <= ptr_d;
      overrun_q   <= overrun_d;
      clk_en_q    <= clk_en_d;
      cpu_rst_q   <= cpu_rst_d;
      is_write_q  <= is_write_d;
      is_status_q <= is_status_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign tx_data    = tx_sh[7:0];
  assign tx_valid   = (state_q == StTx);
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign cpu_clk_en = clk_en_q;
  assign cpu_reset  = cpu_rst_q;

endmodule
